// File: rtl/sim_fp_mac_pipe.sv
// Simulation-only single-precision multiply-add PE: valid/ready input, a stallable
// LATENCY-stage result pipe and an internal accumulator chained through mode=1 beats.
module sim_fp_mac_pipe #(
    parameter int LATENCY         = 2,
    parameter int sig_width       = 23,
    parameter int exp_width       = 8,
    parameter int ieee_compliance = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic        mode,
    input  logic        acc_clr,
    input  logic [2:0]  rnd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic [7:0]  status,
    output logic [31:0] acc,
    output logic        busy
);

    localparam int MW = sig_width;
    localparam int EW = exp_width;

    // Exact value of the smallest single denormal, 2**-149.
    localparam real DENORM_ULP = 1.401298464324817e-45;

    function automatic logic [7:0] fp_status(input logic [31:0] v);
        logic exp_ones;
        logic exp_zero;
        logic man_zero;
        exp_ones = &v[MW+EW-1:MW];
        exp_zero = ~|v[MW+EW-1:MW];
        man_zero = ~|v[MW-1:0];
        return {5'd0, exp_ones & ~man_zero, exp_ones & man_zero, exp_zero & man_zero};
    endfunction

    // Widen single bits to a double; every single is exactly representable.
    function automatic real sp_to_real(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        real         r;
        e = v[30:23];
        m = v[22:0];
        if (e == 8'hFF) begin
            r = $bitstoreal({v[31], 11'h7FF, m, 29'd0});
        end else if (e != 8'h00) begin
            r = $bitstoreal({v[31], {3'd0, e} + 11'd896, m, 29'd0});
        end else begin
            r = $itor({9'd0, m}) * DENORM_ULP;
            r = v[31] ? -r : r;
        end
        return r;
    endfunction

    // Round a double to single bits, round-to-nearest-even, with overflow to
    // infinity and gradual underflow into single denormals.
    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [10:0] ed;
        logic [52:0] sig;
        logic [52:0] rem;
        logic [30:0] mag;
        logic        grd;
        logic        stk;
        int          es;
        int          t;
        d   = $realtobits(r);
        ed  = d[62:52];
        sig = {1'b1, d[51:0]};
        es  = $signed({21'd0, ed}) - 32'sd896;
        grd = 1'b0;
        stk = 1'b0;
        rem = 53'd0;
        t   = 32'sd0;
        if (ed == 11'h7FF) begin
            mag = (d[51:0] != 52'd0) ? {8'hFF, 1'b1, d[50:29]} : {8'hFF, 23'd0};
        end else if (ed == 11'd0 || es < -32'sd23) begin
            mag = 31'd0;
        end else if (es >= 32'sd255) begin
            mag = {8'hFF, 23'd0};
        end else if (es >= 32'sd1) begin
            mag = {es[7:0], d[51:29]};
            grd = d[28];
            stk = |d[27:0];
        end else begin
            // Denormal result: shift the full significand right by 30..53.
            t   = 32'sd30 - es;
            mag = {8'd0, 23'(sig >> t)};
            rem = sig & ~({53{1'b1}} << t);
            grd = rem[t-1];
            stk = |(rem & ~({53{1'b1}} << (t - 32'sd1)));
        end
        if (grd && (stk || mag[0])) begin
            mag = mag + 31'd1;
        end else begin
            mag = mag;
        end
        return {d[63], mag};
    endfunction

    // Product and sum are each rounded to single, matching shortreal a*b + w.
    function automatic logic [31:0] fp_mac(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] w);
        logic [31:0] prod;
        prod = real_to_sp(sp_to_real(x) * sp_to_real(y));
        return real_to_sp(sp_to_real(prod) + sp_to_real(w));
    endfunction

    logic        vld_q     [LATENCY];
    logic        vld_d     [LATENCY];
    logic [31:0] z_q       [LATENCY];
    logic [31:0] z_d       [LATENCY];
    logic [7:0]  st_q      [LATENCY];
    logic [7:0]  st_d      [LATENCY];
    logic        isacc_q   [LATENCY];
    logic        isacc_d   [LATENCY];
    logic        nxt_vld_s [LATENCY];
    logic [31:0] nxt_z_s   [LATENCY];
    logic [7:0]  nxt_st_s  [LATENCY];
    logic        nxt_acc_s [LATENCY];

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic        acc_pending_q;
    logic        acc_pending_d;
    logic        busy_q;
    logic        busy_d;

    logic        en_s;
    logic        accept_s;
    logic        acc_beat_s;
    logic        acc_wr_s;
    logic        acc_clr_s;
    logic [31:0] addend_s;
    logic [31:0] z_new_s;
    logic        unused_s;

    assign unused_s = ^{rnd, 1'(ieee_compliance)};

    // Handshake and the arithmetic for the beat on the input port.
    always_comb begin
        en_s       = !vld_q[LATENCY-1] || out_ready;
        in_ready   = rst_n && en_s && !(mode && acc_pending_q);
        accept_s   = in_valid && in_ready;
        acc_beat_s = accept_s && mode;
        addend_s   = mode ? (acc_clr ? 32'h0000_0000 : acc_q) : c;
        z_new_s    = fp_mac(a, b, addend_s);
    end

    // What each stage would load on an advance: the new beat or its predecessor.
    always_comb begin
        nxt_vld_s[0] = accept_s;
        nxt_z_s[0]   = z_new_s;
        nxt_st_s[0]  = fp_status(z_new_s);
        nxt_acc_s[0] = mode;
        for (int i = 1; i < LATENCY; i++) begin
            nxt_vld_s[i] = vld_q[i-1];
            nxt_z_s[i]   = z_q[i-1];
            nxt_st_s[i]  = st_q[i-1];
            nxt_acc_s[i] = isacc_q[i-1];
        end
    end

    // Stage next-state, accumulator write-back and the hazard flag.
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            vld_d[i]   = en_s ? nxt_vld_s[i] : vld_q[i];
            z_d[i]     = (en_s && nxt_vld_s[i]) ? nxt_z_s[i] : z_q[i];
            st_d[i]    = (en_s && nxt_vld_s[i]) ? nxt_st_s[i] : st_q[i];
            isacc_d[i] = (en_s && nxt_vld_s[i]) ? nxt_acc_s[i] : isacc_q[i];
            busy_d     = busy_d | vld_d[i];
        end
        // A mode-1 beat updates acc on the edge it becomes the visible result.
        acc_wr_s  = en_s && nxt_vld_s[LATENCY-1] && nxt_acc_s[LATENCY-1];
        acc_clr_s = acc_clr && !acc_pending_q && (!in_valid || (accept_s && !mode));
        if (acc_wr_s) begin
            acc_pending_d = 1'b0;
        end else if (acc_beat_s) begin
            acc_pending_d = 1'b1;
        end else begin
            acc_pending_d = acc_pending_q;
        end
        if (acc_wr_s) begin
            acc_d = nxt_z_s[LATENCY-1];
        end else if (acc_clr_s) begin
            acc_d = 32'h0000_0000;
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i]   <= 1'b0;
                z_q[i]     <= 32'h0000_0000;
                st_q[i]    <= 8'h00;
                isacc_q[i] <= 1'b0;
            end
            acc_q         <= 32'h0000_0000;
            acc_pending_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i]   <= vld_d[i];
                z_q[i]     <= z_d[i];
                st_q[i]    <= st_d[i];
                isacc_q[i] <= isacc_d[i];
            end
            acc_q         <= acc_d;
            acc_pending_q <= acc_pending_d;
            busy_q        <= busy_d;
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign z         = z_q[LATENCY-1];
    assign status    = st_q[LATENCY-1];
    assign acc       = acc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sim_fp_mac_pipe.sv
// Self-checking bench for sim_fp_mac_pipe (LATENCY=2): vector table plus
// hand-written multi-cycle sequences, results checked through a scoreboard queue.
module tb_sim_fp_mac_pipe;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        mode;
    logic        acc_clr;
    logic [2:0]  rnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [7:0]  status;
    logic [31:0] acc;
    logic        busy;

    always #5 clk = ~clk;

    sim_fp_mac_pipe #(.LATENCY(LAT), .sig_width(23), .exp_width(8), .ieee_compliance(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .mode(mode), .acc_clr(acc_clr), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .status(status),
        .acc(acc), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vc;
        logic        vmode;
        logic        vclr;
        logic [31:0] ez;
        logic [7:0]  est;
        logic        enan;
    } vec_t;

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  st;
        logic        nan;
    } exp_t;

    vec_t vecs [7];
    exp_t sb_q [$];
    exp_t mon_e;
    int   acc_cyc_q [$];
    int   out_cyc_q [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    int   n0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: every completed output handshake is compared in order.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            out_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got z=%h expected no result", z);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_status", 32'(status), 32'(mon_e.st));
                if (mon_e.nan) begin
                    check("out_nan_exp", 32'(z[30:23]), 32'h0000_00FF);
                    check("out_nan_man", 32'(|z[22:0]), 32'd1);
                end else begin
                    check("out_z", z, mon_e.z);
                end
            end
        end
    end

    // Present one beat from posedge+1 and hold it until it is accepted.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tc,
                        input logic tm, input logic tclr, input logic [31:0] ez,
                        input logic [7:0] est, input logic enan);
        a = ta; b = tb; c = tc; mode = tm; acc_clr = tclr; in_valid = 1'b1;
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back({ez, est, enan});
                acc_cyc_q.push_back(cyc);
                @(posedge clk); #1;
                in_valid = 1'b0;
                acc_clr  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: got in_ready=0 for 64 cycles expected acceptance");
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic send_vec(input vec_t v);
        send(v.va, v.vb, v.vc, v.vmode, v.vclr, v.ez, v.est, v.enan);
    endtask

    task automatic drain();
        for (int w = 0; w < 100; w++) begin
            if (sb_q.size() == 0) return;
            @(posedge clk); #1;
        end
        n_checks++;
        n_errors++;
        $display("FAIL drain_timeout: got %0d outstanding expected 0", sb_q.size());
    endtask

    initial begin
        vecs[0] = {32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 8'h00, 1'b0};
        vecs[1] = {32'h40200000, 32'h40800000, 32'hBF800000, 1'b0, 1'b0, 32'h41100000, 8'h00, 1'b0};
        vecs[2] = {32'h3F000000, 32'hC0C00000, 32'h3E800000, 1'b0, 1'b0, 32'hC0300000, 8'h00, 1'b0};
        vecs[3] = {32'h3FC00000, 32'h3FC00000, 32'h00000000, 1'b0, 1'b0, 32'h40100000, 8'h00, 1'b0};
        vecs[4] = {32'h00000000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 32'h7FC00000, 8'h04, 1'b1};
        vecs[5] = {32'h7E967699, 32'h7E967699, 32'h00000000, 1'b0, 1'b0, 32'h7F800000, 8'h02, 1'b0};
        vecs[6] = {32'hC0000000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h00000000, 8'h01, 1'b0};

        // T1: reset held with a valid beat offered
        rst_n = 1'b0; in_valid = 1'b1; mode = 1'b0; acc_clr = 1'b0; rnd = 3'd0; out_ready = 1'b1;
        a = 32'h40400000; b = 32'h40000000; c = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", z, 32'h0000_0000);
        check("rst_acc", acc, 32'h0000_0000);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T2: single beat latency, then four back-to-back table vectors
        send(32'h40400000, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, 32'h40E00000, 8'h00, 1'b0);
        check("t2_valid_cycle1", 32'(out_valid), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t2_valid_cycle2", 32'(out_valid), 32'd1);
        check("t2_z", z, 32'h40E00000);
        check("t2_status", 32'(status), 32'd0);
        drain();
        acc_cyc_q.delete();
        out_cyc_q.delete();
        for (int i = 0; i < 4; i++) send_vec(vecs[i]);
        drain();
        check("t2_b2b_accepts", 32'(acc_cyc_q.size()), 32'd4);
        check("t2_b2b_results", 32'(out_cyc_q.size()), 32'd4);
        if (acc_cyc_q.size() == 4 && out_cyc_q.size() == 4) begin
            check("t2_accept_span", 32'(acc_cyc_q[3] - acc_cyc_q[0]), 32'd3);
            check("t2_result_span", 32'(out_cyc_q[3] - out_cyc_q[0]), 32'd3);
        end

        // T3: back-pressure on the first result for five cycles
        out_ready = 1'b0;
        n0 = n_out;
        fork
            begin
                send(32'h40400000, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, 32'h40E00000, 8'h00, 1'b0);
                send_vec(vecs[0]);
                send_vec(vecs[1]);
            end
            begin
                for (int w = 0; w < 20 && !out_valid; w++) begin
                    @(posedge clk); #1;
                end
                for (int h = 0; h < 5; h++) begin
                    check("t3_hold_valid", 32'(out_valid), 32'd1);
                    check("t3_hold_z", z, 32'h40E00000);
                    check("t3_in_ready", 32'(in_ready), 32'd0);
                    check("t3_busy", 32'(busy), 32'd1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("t3_result_count", 32'(n_out - n0), 32'd3);

        // T4: accumulate chain 2, 4, 6, 8 (c is ignored in mode 1)
        acc_cyc_q.delete();
        send(32'h3F800000, 32'h40000000, 32'h3F800000, 1'b1, 1'b1, 32'h40000000, 8'h00, 1'b0);
        send(32'h3F800000, 32'h40000000, 32'h3F800000, 1'b1, 1'b0, 32'h40800000, 8'h00, 1'b0);
        send(32'h3F800000, 32'h40000000, 32'h3F800000, 1'b1, 1'b0, 32'h40C00000, 8'h00, 1'b0);
        send(32'h3F800000, 32'h40000000, 32'h3F800000, 1'b1, 1'b0, 32'h41000000, 8'h00, 1'b0);
        drain();
        for (int i = 1; i < 4 && i < acc_cyc_q.size(); i++) begin
            check("t4_accept_spacing", 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'(LAT));
        end
        check("t4_acc", acc, 32'h41000000);

        // T5: mode-0 beat issued behind a pending mode-1 beat, then acc_clr cases
        acc_cyc_q.delete();
        send(32'h3F800000, 32'h40000000, 32'h40A00000, 1'b1, 1'b0, 32'h41200000, 8'h00, 1'b0);
        send(32'h40400000, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, 32'h40E00000, 8'h00, 1'b0);
        if (acc_cyc_q.size() == 2) begin
            check("t5_mode0_no_stall", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd1);
        end
        drain();
        check("t5_acc_after_mixed", acc, 32'h41200000);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        check("t5_standalone_clear", acc, 32'h0000_0000);
        send(32'h3F800000, 32'h40000000, 32'h00000000, 1'b1, 1'b1, 32'h40000000, 8'h00, 1'b0);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        check("t5_clear_while_pending", acc, 32'h40000000);
        drain();

        // T6: status flags from the table
        for (int i = 4; i < 7; i++) send_vec(vecs[i]);
        drain();

        // T1b: reset with two beats in flight; neither may ever appear
        send_vec(vecs[0]);
        send_vec(vecs[1]);
        rst_n = 1'b0;
        sb_q.delete();
        n0 = n_out;
        #1;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_acc", acc, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst2_no_output", 32'(n_out - n0), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_out_valid_after", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
